// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared types and defaults for the multiply/divide controller.
//   md_op_e    : EX-stage md operation code (4 bits, MD_NONE when idle)
//   md_state_e : controller state (IDLE, RUN)
//   *_DEF      : default busy-cycle counts and countdown width
// ----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/md_arith.sv
// ----------------------------------------------------------------------------
// md_arith
// Purely combinational multiply/divide datapath.
//   i_op    : md operation code (only MULT/MULTU/DIV/DIVU produce a result)
//   i_rs    : multiplicand / dividend
//   i_rt    : multiplier / divisor
//   o_res   : {hi, lo}; product for mult, {remainder, quotient} for div
//   o_div0  : divide op with a zero divisor (o_res is then meaningless)
// ----------------------------------------------------------------------------
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_res,
    output logic        o_div0
);

    logic        w_is_signed;
    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [63:0] w_prod;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;

    assign w_is_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_is_div    = (i_op == MD_DIV)  || (i_op == MD_DIVU);

    // Operands are negative only when the op is signed; this lets one
    // 64-bit multiplier and one unsigned divider serve both flavours.
    assign w_a_neg = w_is_signed & i_rs[31];
    assign w_b_neg = w_is_signed & i_rt[31];

    // Low 64 bits of the product of the extended operands are exact for
    // both signed and unsigned 32x32 multiplication.
    assign w_prod = {{32{w_a_neg}}, i_rs} * {{32{w_b_neg}}, i_rt};

    // Divide on magnitudes, then restore signs. Magnitude of 0x80000000 is
    // 0x80000000 as unsigned, so 0x80000000 / -1 yields 0x80000000, rem 0.
    assign w_ua = w_a_neg ? (32'd0 - i_rs) : i_rs;
    assign w_ub = w_b_neg ? (32'd0 - i_rt) : i_rt;

    assign w_q = (w_ub == 32'd0) ? 32'd0 : (w_ua / w_ub);
    assign w_r = (w_ub == 32'd0) ? 32'd0 : (w_ua % w_ub);

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_q_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
    assign w_r_s = w_a_neg ? (32'd0 - w_r) : w_r;

    assign o_div0 = w_is_div && (i_rt == 32'd0);

    always_comb begin
        o_res = 64'd0;
        if ((i_op == MD_MULT) || (i_op == MD_MULTU)) begin
            o_res = w_prod;
        end else if (w_is_div) begin
            o_res = {w_r_s, w_q_s};
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// ----------------------------------------------------------------------------
// md_ctrl
// Multiply/divide sequencer beside the EX-stage ALU; owns HI/LO.
//   clk      : pipeline clock
//   reset    : asynchronous, active-low reset
//   md_op    : EX-stage md operation (md_op_e encoding)
//   rs_data  : forwarded rs operand
//   rt_data  : forwarded rt operand
//   id_is_md : ID-stage instruction is md-class
//   start    : a mult/div is accepted this cycle (combinational)
//   busy     : a mult/div is in progress (registered)
//   stall_md : ID stall term, id_is_md & (start | busy)
//   rd_data  : HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo   : current HI/LO registers
// ----------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        id_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;

    logic             w_is_muldiv;
    logic             w_is_div;
    logic [63:0]      w_res;
    logic             w_div0;

    md_arith u_arith (
        .i_op   (md_op),
        .i_rs   (rs_data),
        .i_rt   (rt_data),
        .o_res  (w_res),
        .o_div0 (w_div0)
    );

    assign w_is_muldiv = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                         (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign w_is_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);

    assign start    = (r_state == IDLE) && w_is_muldiv;
    assign busy     = r_busy;
    assign stall_md = id_is_md && (start || r_busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_comb begin
        rd_data = 32'd0;
        if (md_op == MD_MFHI) begin
            rd_data = r_hi;
        end else if (md_op == MD_MFLO) begin
            rd_data = r_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // A zero divisor re-commits the current HI/LO at the
                        // end of the run, so the registers appear untouched.
                        if (w_div0) begin
                            r_pend_hi <= r_hi;
                            r_pend_lo <= r_lo;
                        end else begin
                            r_pend_hi <= w_res[63:32];
                            r_pend_lo <= w_res[31:0];
                        end
                        r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else if (md_op == MD_MTHI) begin
                        r_hi <= rs_data;
                    end else if (md_op == MD_MTLO) begin
                        r_lo <= rs_data;
                    end
                end
                RUN: begin
                    // Any md_op here is a protocol violation and is ignored.
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // stall_md should keep md instructions out of EX while the unit is busy.
    always @(posedge clk) begin
        if (reset && r_busy) begin
            assert (md_op == MD_NONE);
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// ----------------------------------------------------------------------------
// tb_md_ctrl
// Scoreboard bench for md_ctrl: each issued mult/div pushes its expected
// HI/LO and busy length; a monitor pops and compares when busy drops.
// ----------------------------------------------------------------------------
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        id_is_md;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .id_is_md (id_is_md),
        .start    (start),
        .busy     (busy),
        .stall_md (stall_md),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          nbusy;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks HI/LO when a run completes.
    int   mon_run  = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            mon_run  = 0;
            mon_prev = 1'b0;
        end else begin
            if (busy) begin
                mon_run++;
            end else if (mon_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_hi"}, 64'(hi), 64'(e.ehi));
                    chk({e.nm, "_lo"}, 64'(lo), 64'(e.elo));
                    chk({e.nm, "_busy_len"}, 64'(mon_run), 64'(e.nbusy));
                end
                mon_run = 0;
            end
            mon_prev = busy;
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int nbusy, output int nstall);
        exp_t e;
        logic done;
        e.nm = nm; e.ehi = ehi; e.elo = elo; e.nbusy = nbusy;
        sb.push_back(e);
        nstall = 0;
        @(posedge clk); #1;
        md_op = op; rs_data = a; rt_data = b;
        @(negedge clk);
        chk({nm, "_start"}, 64'(start), 64'd1);
        if (stall_md) nstall++;
        @(posedge clk); #1;
        md_op = MD_NONE;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, "_start_pulse"}, 64'(start), 64'd0);
            if (stall_md) nstall++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        md_op = op; rs_data = v;
        @(posedge clk); #1;
        md_op = MD_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ns;
        reset = 1'b0; md_op = MD_NONE; rs_data = 32'd0; rt_data = 32'd0; id_is_md = 1'b1;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_stall", 64'(stall_md), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        md_op = MD_MFHI;
        #1 chk("rst_rd", 64'(rd_data), 64'd0);
        md_op = MD_NONE;
        @(posedge clk); #1 reset = 1'b1;

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, ns);
        chk("mult_stall_cnt", 64'(ns), 64'd6);

        id_is_md = 1'b0;
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, ns);
        chk("multu_no_id_stall", 64'(ns), 64'd0);
        id_is_md = 1'b1;

        run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, ns);
        chk("divu_stall_cnt", 64'(ns), 64'd11);

        run_op("divu_big", MD_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 10, ns);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, ns);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, ns);

        do_mt(MD_MTHI, 32'h1234);
        do_mt(MD_MTLO, 32'h5678);
        md_op = MD_MFHI;
        #1 chk("mfhi_rd", 64'(rd_data), 64'h1234);
        md_op = MD_MFLO;
        #1 chk("mflo_rd", 64'(rd_data), 64'h5678);
        md_op = MD_NONE;

        run_op("div0", MD_DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, ns);

        // MULTU aborted by reset during the third busy cycle.
        @(posedge clk); #1;
        md_op = MD_MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        md_op = MD_NONE;
        @(posedge clk); @(posedge clk); #3;
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_stall", 64'(stall_md), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        md_op = MD_MFLO;
        @(negedge clk);
        chk("abort_mflo_rd", 64'(rd_data), 64'd0);
        md_op = MD_NONE;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_late_hi", 64'(hi), 64'd0);
        chk("abort_no_late_lo", 64'(lo), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
